// File: rtl/bmux_pkg.sv
// rtl/bmux_pkg.sv - arbitration mode constants and shared helpers for arb_bmux
package bmux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } arb_mode_t;

    // Index width never collapses to zero bits, even for a two-channel mux.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational fixed-priority / round-robin channel picker
module rr_pick
    import bmux_pkg::*;
#(
    parameter int COUNT = 4,
    parameter int IDX_W = 2
) (
    input  logic [COUNT-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  arb_mode_t        mode_i,
    output logic [COUNT-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o
);

    logic             found;
    int               pos;
    logic [IDX_W-1:0] pos_idx;

    // One-hot grant: highest index in fixed mode, first requester after ptr in RR mode.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        if (mode_i == MODE_FIXED) begin
            // Ascending scan, so the last (highest) requester overwrites earlier ones.
            for (int i = 0; i < COUNT; i++) begin
                if (req_i[i]) begin
                    grant_o    = '0;
                    grant_o[i] = 1'b1;
                    idx_o      = IDX_W'(i);
                end
            end
        end else begin
            // Start one past the last winner and wrap, so the last winner is checked last.
            for (int k = 1; k <= COUNT; k++) begin
                pos     = (int'(ptr_i) + k) % COUNT;
                pos_idx = IDX_W'(pos);
                if (!found && req_i[pos_idx]) begin
                    found            = 1'b1;
                    grant_o[pos_idx] = 1'b1;
                    idx_o            = pos_idx;
                end
            end
        end
    end

endmodule

// File: rtl/arb_bmux.sv
// rtl/arb_bmux.sv - arbitrated N:1 mux with a single registered output stage
module arb_bmux
    import bmux_pkg::*;
#(
    parameter int        COUNT = 4,
    parameter int        WIDTH = 32,
    parameter arb_mode_t MODE  = MODE_RR,
    localparam int       IDX_W = idx_width(COUNT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [COUNT-1:0] in_valid,
    input  logic [WIDTH-1:0] in_data [COUNT-1:0],
    output logic [COUNT-1:0] in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready
);

    logic [COUNT-1:0] grant;
    logic [IDX_W-1:0] pick_idx;
    logic             load_en;
    logic             xfer;

    logic [IDX_W-1:0] ptr_q,       ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [IDX_W-1:0] out_idx_q,   out_idx_d;

    rr_pick #(
        .COUNT (COUNT),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (in_valid),
        .ptr_i   (ptr_q),
        .mode_i  (MODE),
        .grant_o (grant),
        .idx_o   (pick_idx)
    );

    // The output register can take a word when empty or being drained this cycle.
    assign load_en  = !out_valid_q || out_ready;
    assign xfer     = load_en && (|in_valid);
    assign in_ready = grant & {COUNT{load_en}};

    // Next state: load on transfer, clear to the no-drive value on a bare drain, else hold.
    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        if (xfer) begin
            ptr_d       = pick_idx;
            out_valid_d = 1'b1;
            out_data_d  = in_data[pick_idx];
            out_idx_d   = pick_idx;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_idx_d   = '0;
        end
    end

    // ptr resets to the last channel so channel 0 is searched first after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= IDX_W'(COUNT - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_arb_bmux.sv
// tb/tb_arb_bmux.sv - self-checking bench for arb_bmux (4ch RR, 4ch fixed, 5ch RR)
module tb_arb_bmux;
    import bmux_pkg::*;

    logic clk;
    logic rst_n;

    logic [3:0]  va;  logic [31:0] da [3:0]; logic [3:0] ra; logic ova; logic [31:0] oda; logic [1:0] oia; logic ora;
    logic [3:0]  vb;  logic [31:0] db [3:0]; logic [3:0] rb; logic ovb; logic [31:0] odb; logic [1:0] oib; logic orb;
    logic [4:0]  vc;  logic [31:0] dc [4:0]; logic [4:0] rc; logic ovc; logic [31:0] odc; logic [2:0] oic; logic orc;

    int checks   = 0;
    int failures = 0;

    int          m_ptr   [3];
    logic        m_valid [3];
    logic [34:0] m_word  [3];
    logic [34:0] sb_q [$];

    arb_bmux #(.COUNT(4), .WIDTH(32), .MODE(MODE_RR)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(va), .in_data(da), .in_ready(ra),
        .out_valid(ova), .out_data(oda), .out_idx(oia), .out_ready(ora));

    arb_bmux #(.COUNT(4), .WIDTH(32), .MODE(MODE_FIXED)) u_fx (
        .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_data(db), .in_ready(rb),
        .out_valid(ovb), .out_data(odb), .out_idx(oib), .out_ready(orb));

    arb_bmux #(.COUNT(5), .WIDTH(32), .MODE(MODE_RR)) u_c5 (
        .clk(clk), .rst_n(rst_n), .in_valid(vc), .in_data(dc), .in_ready(rc),
        .out_valid(ovc), .out_data(odc), .out_idx(oic), .out_ready(orc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    function automatic int model_pick(input int n, input bit rr, input logic [7:0] v, input int p);
        int j;
        model_pick = -1;
        if (rr) begin
            for (int k = 1; k <= n; k++) begin
                j = (p + k) % n;
                if (model_pick < 0 && v[j[2:0]]) model_pick = j;
            end
        end else begin
            for (int i = n - 1; i >= 0; i--)
                if (model_pick < 0 && v[i[2:0]]) model_pick = i;
        end
    endfunction

    function automatic logic [31:0] data_of(input int sel, input int g);
        case (sel)
            0:       return da[g[1:0]];
            1:       return db[g[1:0]];
            default: return dc[g[2:0]];
        endcase
    endfunction

    task automatic sample(input int sel, output logic [7:0] rdy, output logic ov,
                          output logic [31:0] od, output logic [2:0] oi);
        rdy = '0;
        oi  = '0;
        case (sel)
            0:       begin rdy[3:0] = ra; ov = ova; od = oda; oi[1:0] = oia; end
            1:       begin rdy[3:0] = rb; ov = ovb; od = odb; oi[1:0] = oib; end
            default: begin rdy[4:0] = rc; ov = ovc; od = odc; oi = oic; end
        endcase
    endtask

    task automatic fill(input int sel);
        for (int i = 0; i < 5; i++) begin
            if (sel == 0 && i < 4) da[i] = $urandom;
            if (sel == 1 && i < 4) db[i] = $urandom;
            if (sel == 2) dc[i] = $urandom;
        end
    endtask

    task automatic model_reset();
        m_ptr[0] = 3; m_ptr[1] = 3; m_ptr[2] = 4;
        for (int s = 0; s < 3; s++) begin
            m_valid[s] = 1'b0;
            m_word[s]  = '0;
        end
        sb_q.delete();
    endtask

    // One clock of stimulus on DUT 'sel'; the other two are frozen (no requests, no drain).
    task automatic step(input int sel, input logic [7:0] v, input logic ordy);
        int          n;
        bit          rr;
        int          g;
        bit          load;
        bit          loaded;
        logic [7:0]  exp_rdy;
        logic [7:0]  rdy;
        logic        ov;
        logic [31:0] od;
        logic [2:0]  oi;
        n  = (sel == 2) ? 5 : 4;
        rr = (sel != 1);
        va = '0; vb = '0; vc = '0; ora = 1'b0; orb = 1'b0; orc = 1'b0;
        case (sel)
            0:       begin va = v[3:0]; ora = ordy; end
            1:       begin vb = v[3:0]; orb = ordy; end
            default: begin vc = v[4:0]; orc = ordy; end
        endcase
        #1;
        g       = model_pick(n, rr, v, m_ptr[sel]);
        load    = !m_valid[sel] || ordy;
        exp_rdy = '0;
        if (load && g >= 0) exp_rdy[g[2:0]] = 1'b1;
        sample(sel, rdy, ov, od, oi);
        checks++;
        if (rdy !== exp_rdy) begin
            failures++;
            $display("FAIL in_ready dut%0d got %b expected %b", sel, rdy, exp_rdy);
        end
        loaded = 1'b0;
        if (load && g >= 0) begin
            sb_q.push_back({g[2:0], data_of(sel, g)});
            m_ptr[sel]   = g;
            m_valid[sel] = 1'b1;
            loaded       = 1'b1;
        end else if (m_valid[sel] && ordy) begin
            m_valid[sel] = 1'b0;
        end
        @(posedge clk);
        #1;
        if (loaded && sb_q.size() > 0) m_word[sel] = sb_q.pop_front();
        sample(sel, rdy, ov, od, oi);
        checks++;
        if (ov !== m_valid[sel]) begin
            failures++;
            $display("FAIL out_valid dut%0d got %b expected %b", sel, ov, m_valid[sel]);
        end
        checks++;
        if (m_valid[sel]) begin
            if (od !== m_word[sel][31:0] || oi !== m_word[sel][34:32]) begin
                failures++;
                $display("FAIL out_word dut%0d got idx=%0d data=%h expected idx=%0d data=%h",
                         sel, oi, od, m_word[sel][34:32], m_word[sel][31:0]);
            end
        end else begin
            if (od !== 32'h0 || oi !== 3'h0) begin
                failures++;
                $display("FAIL out_idle dut%0d got idx=%0d data=%h expected 0/0", sel, oi, od);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [7:0]  rdy;
        logic        ov;
        logic [31:0] od;
        logic [2:0]  oi;
        for (int s = 0; s < 3; s++) begin
            sample(s, rdy, ov, od, oi);
            checks++;
            if (ov !== 1'b0 || od !== 32'h0 || oi !== 3'h0) begin
                failures++;
                $display("FAIL %s dut%0d got valid=%b data=%h idx=%0d expected 0/0/0", tag, s, ov, od, oi);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        va = '0; vb = '0; vc = '0; ora = 1'b0; orb = 1'b0; orc = 1'b0;
        fill(0); fill(1); fill(2);
        model_reset();
        #1;
        check_reset_outputs("reset_state");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        #2 rst_n = 1'b1;
    endtask

    task automatic test_rr_rotation();
        logic [7:0] rdy; logic ov; logic [31:0] od; logic [2:0] oi;
        for (int i = 0; i < 8; i++) begin
            fill(0);
            step(0, 8'h0F, 1'b1);
            sample(0, rdy, ov, od, oi);
            checks++;
            if (ov !== 1'b1 || oi !== 3'(i % 4)) begin
                failures++;
                $display("FAIL rr_seq[%0d] got valid=%b idx=%0d expected 1/%0d", i, ov, oi, i % 4);
            end
        end
        step(0, 8'h00, 1'b1);
    endtask

    task automatic test_single();
        logic [7:0] rdy; logic ov; logic [31:0] od; logic [2:0] oi;
        fill(0);
        step(0, 8'h08, 1'b1);
        sample(0, rdy, ov, od, oi);
        checks++;
        if (ov !== 1'b1 || oi !== 3'd3) begin
            failures++;
            $display("FAIL single_load got valid=%b idx=%0d expected 1/3", ov, oi);
        end
        step(0, 8'h00, 1'b1);
        sample(0, rdy, ov, od, oi);
        checks++;
        if (ov !== 1'b0 || od !== 32'h0) begin
            failures++;
            $display("FAIL single_drain got valid=%b data=%h expected 0/0", ov, od);
        end
        step(0, 8'h00, 1'b1);
    endtask

    task automatic test_stall();
        logic [7:0] rdy; logic ov; logic [31:0] od; logic [2:0] oi;
        fill(0);
        da[1] = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h02, 1'b0);
            fill(0);
        end
        sample(0, rdy, ov, od, oi);
        checks++;
        if (ov !== 1'b1 || od !== 32'hDEAD_BEEF || oi !== 3'd1) begin
            failures++;
            $display("FAIL stall_hold got valid=%b data=%h idx=%0d expected 1/deadbeef/1", ov, od, oi);
        end
        step(0, 8'h00, 1'b1);
        step(0, 8'h0F, 1'b1);
        sample(0, rdy, ov, od, oi);
        checks++;
        if (oi !== 3'd2) begin
            failures++;
            $display("FAIL stall_next_grant got idx=%0d expected 2", oi);
        end
        step(0, 8'h00, 1'b1);
    endtask

    task automatic test_fixed();
        logic [7:0] rdy; logic ov; logic [31:0] od; logic [2:0] oi;
        for (int i = 0; i < 5; i++) begin
            fill(1);
            step(1, 8'h05, 1'b1);
            sample(1, rdy, ov, od, oi);
            checks++;
            if (ov !== 1'b1 || oi !== 3'd2 || rdy[0] !== 1'b0) begin
                failures++;
                $display("FAIL fixed[%0d] got valid=%b idx=%0d rdy0=%b expected 1/2/0", i, ov, oi, rdy[0]);
            end
        end
        step(1, 8'h00, 1'b1);
    endtask

    task automatic test_count5();
        logic [7:0] rdy; logic ov; logic [31:0] od; logic [2:0] oi;
        for (int i = 0; i < 7; i++) begin
            fill(2);
            step(2, 8'h1F, 1'b1);
            sample(2, rdy, ov, od, oi);
            checks++;
            if (oi !== 3'(i % 5) || oi >= 3'd5) begin
                failures++;
                $display("FAIL c5_seq[%0d] got idx=%0d expected %0d", i, oi, i % 5);
            end
        end
        step(2, 8'h00, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            fill(0);
            step(0, 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 40; i++) begin
            fill(2);
            step(2, 8'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 20; i++) begin
            fill(1);
            step(1, 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_midreset();
        logic [7:0] rdy; logic ov; logic [31:0] od; logic [2:0] oi;
        fill(0);
        step(0, 8'h0F, 1'b1);
        step(0, 8'h0F, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset_async");
        model_reset();
        va = '0; vb = '0; vc = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        fill(0);
        step(0, 8'h0F, 1'b1);
        sample(0, rdy, ov, od, oi);
        checks++;
        if (ov !== 1'b1 || oi !== 3'd0) begin
            failures++;
            $display("FAIL post_reset_grant got valid=%b idx=%0d expected 1/0", ov, oi);
        end
        step(0, 8'h00, 1'b1);
    endtask

    initial begin
        test_reset();
        test_rr_rotation();
        test_single();
        test_stall();
        test_fixed();
        test_count5();
        test_random();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
